// File: rtl/rst_seq_pkg.sv
// Shared constants for the board reset sequencer: FSM encodings and synchroniser depth.
package rst_seq_pkg;

  localparam logic [1:0] ST_PWR = 2'd0;
  localparam logic [1:0] ST_REL = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/reset_hold_ch.sv
// One downstream reset channel: active-low output bit plus its soft-reset hold counter.
module reset_hold_ch #(
  parameter int HOLD_CYC = 254
) (
  input  logic clk_125,
  input  logic rst_sync_n,
  input  logic req,
  input  logic load,
  input  logic clr,
  input  logic run,
  output logic rst_n
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  logic [HOLD_W-1:0] hold;

  // clr (push-button) wins over the sequencer release, which wins over soft requests
  always_ff @(posedge clk_125 or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rst_n <= 1'b0;
      hold  <= '0;
    end else if (clr) begin
      rst_n <= 1'b0;
      hold  <= '0;
    end else if (load) begin
      rst_n <= 1'b1;
    end else if (run) begin
      if (req) begin
        rst_n <= 1'b0;
        hold  <= HOLD_W'(HOLD_CYC - 1);
      end else if (!rst_n) begin
        if (hold == '0) rst_n <= 1'b1;
        else            hold  <= hold - HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / push-button reset sequencer: releases NUM_CH reset domains in order after a delay.
//   state  | meaning
//   ST_PWR | power-on delay counting, all channels held
//   ST_REL | staggered release of channels 1..NUM_CH-1
//   ST_RUN | all released, soft resets serviced per channel
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PWR_CYC     = 1048576,
  parameter int STAGGER_CYC = 254,
  parameter int HOLD_CYC    = 254
) (
  input  logic              clk_125,
  input  logic              rstn,
  input  logic              btn_n,
  input  logic [NUM_CH-1:0] soft_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              all_ready,
  output logic [1:0]        state_dbg
);

  localparam int CNT_MAX = (PWR_CYC > STAGGER_CYC) ? PWR_CYC : STAGGER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   rst_sync_n;
  logic                   btn_sync;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       ch_idx;
  logic                   pwr_done;
  logic                   stg_done;
  logic [NUM_CH-1:0]      load_vec;

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) rst_sync_q <= '0;
    else       rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) btn_sync_q <= '1;
    else       btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
  end
  assign btn_sync = btn_sync_q[SYNC_STAGES-1];

  assign pwr_done = (state == ST_PWR) && (cnt == CNT_W'(PWR_CYC - 1));
  assign stg_done = (state == ST_REL) && (cnt == CNT_W'(STAGGER_CYC - 1));

  always_ff @(posedge clk_125 or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state  <= ST_PWR;
      cnt    <= '0;
      ch_idx <= '0;
    end else if (!btn_sync) begin
      state  <= ST_PWR;
      cnt    <= '0;
      ch_idx <= '0;
    end else begin
      case (state)
        ST_PWR: begin
          if (pwr_done) begin
            cnt    <= '0;
            ch_idx <= IDX_W'(1);
            state  <= (NUM_CH == 1) ? ST_RUN : ST_REL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (stg_done) begin
            cnt    <= '0;
            ch_idx <= ch_idx + IDX_W'(1);
            if (ch_idx == IDX_W'(NUM_CH - 1)) state <= ST_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN:  ;
        default: state <= ST_PWR;
      endcase
    end
  end

  always_comb begin
    load_vec    = '0;
    load_vec[0] = pwr_done;
    for (int i = 1; i < NUM_CH; i++)
      load_vec[i] = stg_done && (ch_idx == IDX_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    reset_hold_ch #(
      .HOLD_CYC(HOLD_CYC)
    ) u_ch (
      .clk_125   (clk_125),
      .rst_sync_n(rst_sync_n),
      .req       (soft_rst_req[g]),
      .load      (load_vec[g]),
      .clr       (!btn_sync),
      .run       (state == ST_RUN),
      .rst_n     (rst_n_out[g])
    );
  end

  assign all_ready = (state == ST_RUN) && (&rst_n_out);
  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-channel instance and a 1-channel instance.
module tb_reset_sequencer;

  logic       clk_125 = 1'b0;
  logic       rstn;
  logic       btn_n;
  logic [2:0] soft_rst_req;
  logic [2:0] rst_n_out;
  logic       all_ready;
  logic [1:0] state_dbg;

  logic       btn_n1;
  logic [0:0] soft_rst_req1;
  logic [0:0] rst_n_out1;
  logic       all_ready1;
  logic [1:0] state_dbg1;

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;

  always #5 clk_125 = ~clk_125;

  reset_sequencer #(.NUM_CH(3), .PWR_CYC(16), .STAGGER_CYC(4), .HOLD_CYC(8)) dut (
    .clk_125     (clk_125),
    .rstn        (rstn),
    .btn_n       (btn_n),
    .soft_rst_req(soft_rst_req),
    .rst_n_out   (rst_n_out),
    .all_ready   (all_ready),
    .state_dbg   (state_dbg)
  );

  reset_sequencer #(.NUM_CH(1), .PWR_CYC(5), .STAGGER_CYC(1), .HOLD_CYC(2)) dut1 (
    .clk_125     (clk_125),
    .rstn        (rstn),
    .btn_n       (btn_n1),
    .soft_rst_req(soft_rst_req1),
    .rst_n_out   (rst_n_out1),
    .all_ready   (all_ready1),
    .state_dbg   (state_dbg1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance to 1 ns after edge k, counting edges from T0 = 0
  task automatic go(input int k);
    repeat (k - cur) @(posedge clk_125);
    #1;
    cur = k;
  endtask

  task automatic chk3(input string tag, input logic [2:0] out_exp, input logic rdy_exp,
                      input logic [1:0] st_exp);
    chk({tag, "_out"}, 32'(rst_n_out), 32'(out_exp));
    chk({tag, "_rdy"}, 32'(all_ready), 32'(rdy_exp));
    chk({tag, "_st"},  32'(state_dbg), 32'(st_exp));
  endtask

  initial begin
    rstn          = 1'b1;
    btn_n         = 1'b1;
    btn_n1        = 1'b1;
    soft_rst_req  = 3'b111;
    soft_rst_req1 = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk3("reset", 3'b000, 1'b0, 2'd0);
    chk("reset_1ch_out", 32'(rst_n_out1), 32'd0);

    // release rstn so the next rising edge is T0; soft requests held high through PWR/REL
    repeat (2) @(posedge clk_125);
    #1 rstn = 1'b1;
    cur = -1;

    go(5);
    chk("one_ch_pre_out", 32'(rst_n_out1), 32'd0);
    chk("one_ch_pre_rdy", 32'(all_ready1), 32'd0);
    go(6);
    chk("one_ch_rel_out", 32'(rst_n_out1), 32'd1);
    chk("one_ch_rel_rdy", 32'(all_ready1), 32'd1);
    chk("one_ch_rel_st",  32'(state_dbg1), 32'd2);

    go(16); chk3("pwr_end",  3'b000, 1'b0, 2'd0);
    go(17); chk3("ch0_rel",  3'b001, 1'b0, 2'd1);
    go(20); chk3("ch0_hold", 3'b001, 1'b0, 2'd1);
    go(21); chk3("ch1_rel",  3'b011, 1'b0, 2'd1);
    go(24); chk3("ch1_hold", 3'b011, 1'b0, 2'd1);
    go(25); chk3("ch2_rel",  3'b111, 1'b1, 2'd2);
    soft_rst_req = 3'b000;
    go(26); chk3("run_idle", 3'b111, 1'b1, 2'd2);

    // single-cycle soft request on ch1, sampled at edge 31
    go(30); soft_rst_req = 3'b010;
    go(31); soft_rst_req = 3'b000;
    chk3("soft1_start", 3'b101, 1'b0, 2'd2);
    go(38); chk3("soft1_last", 3'b101, 1'b0, 2'd2);
    go(39); chk3("soft1_end",  3'b111, 1'b1, 2'd2);

    // ch2 requested at edge 41 and again at 46; release at 54
    go(40); soft_rst_req = 3'b100;
    go(41); soft_rst_req = 3'b000;
    chk3("soft2_start", 3'b011, 1'b0, 2'd2);
    go(45); soft_rst_req = 3'b100;
    go(46); soft_rst_req = 3'b000;
    chk3("soft2_reload", 3'b011, 1'b0, 2'd2);
    go(49); chk3("soft2_noexp", 3'b011, 1'b0, 2'd2);
    go(53); chk3("soft2_last",  3'b011, 1'b0, 2'd2);
    go(54); chk3("soft2_end",   3'b111, 1'b1, 2'd2);

    // push-button low after edge 60 for 10 cycles, released after edge B = 70
    go(60); btn_n = 1'b0;
    go(62); chk3("btn_sync_lag", 3'b111, 1'b1, 2'd2);
    go(63); chk3("btn_clear",    3'b000, 1'b0, 2'd0);
    go(70); btn_n = 1'b1;
    chk3("btn_held", 3'b000, 1'b0, 2'd0);
    go(87); chk3("btn_pre_ch0", 3'b000, 1'b0, 2'd0);
    go(88); chk3("btn_ch0",     3'b001, 1'b0, 2'd1);
    go(92); chk3("btn_ch1",     3'b011, 1'b0, 2'd1);
    go(95); chk3("btn_pre_ch2", 3'b011, 1'b0, 2'd1);
    go(96); chk3("btn_ch2",     3'b111, 1'b1, 2'd2);

    // rstn mid-sequence: restart the button sequence, then assert between ch1 and ch2
    btn_n = 1'b0;
    go(99);
    btn_n = 1'b1;
    go(100 + 2 + 16 + 4 + 1);
    chk3("mid_ch1", 3'b011, 1'b0, 2'd1);
    rstn = 1'b0;
    #1;
    chk3("async_rst", 3'b000, 1'b0, 2'd0);
    repeat (3) @(posedge clk_125);
    #1 rstn = 1'b1;
    cur = -1;
    go(16); chk3("re_pwr_end", 3'b000, 1'b0, 2'd0);
    go(17); chk3("re_ch0",     3'b001, 1'b0, 2'd1);
    go(21); chk3("re_ch1",     3'b011, 1'b0, 2'd1);
    go(24); chk3("re_pre_ch2", 3'b011, 1'b0, 2'd1);
    go(25); chk3("re_ch2",     3'b111, 1'b1, 2'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and soft reset sequencer for the ECP3 Versa boards. It replaces ad-hoc per-domain reset counters with one block clocked on clk_125. The block waits a programmable power-on delay, then releases NUM_CH downstream reset domains (PCIe core, PHY1, PHY2, user logic) one after another, with a fixed stagger between them. It also accepts per-channel soft reset requests and a board push-button that restarts the full sequence.

## Interface
- NUM_CH, 3: number of reset channels, 1..8
- PWR_CYC, 1048576: power-on delay in clk_125 cycles, ≥2
- STAGGER_CYC, 254: cycles between consecutive channel releases, ≥1
- HOLD_CYC, 254: soft-reset low time in cycles, ≥1

Ports:
- clk_125  in  1  system clock, 125 MHz
- rstn  in  1  reset, asynchronous, active-low
- btn_n  in  1  push-button, asynchronous, active-low
- soft_rst_req  in  NUM_CH  per-channel soft reset request, sampled each cycle
- rst_n_out  out  NUM_CH  active-low channel resets
- all_ready  out  1  all channels released and in RUN
- state_dbg  out  2  current state encoding

## Operation
- rstn assertion asynchronously clears all state. rstn deassertion passes through a 2-FF synchroniser (rst_sync_n) before reaching the internal logic.
- btn_n passes through a 2-FF synchroniser that resets to 1, giving btn_sync.
- Reset values:
  - state = PWR
  - cnt = 0
  - ch_idx = 0
  - rst_n_out = all 0
  - all hold counters = 0
  - all_ready = 0
  - state_dbg = 0
- States, with state_dbg encoding PWR=0, REL=1, RUN=2:
  - PWR: cnt increments each cycle. When cnt == PWR_CYC-1:
    - rst_n_out[0] ← 1, cnt ← 0, ch_idx ← 1
    - next state is RUN if NUM_CH == 1, otherwise REL.
  - REL: cnt increments each cycle. When cnt == STAGGER_CYC-1:
    - rst_n_out[ch_idx] ← 1, cnt ← 0, ch_idx ← ch_idx+1
    - go to RUN if ch_idx == NUM_CH-1.
  - RUN: cnt is idle. Per-channel soft reset handling applies.
- Soft reset, RUN state only: if soft_rst_req[i] is high at an edge, then rst_n_out[i] ← 0 and hold[i] ← HOLD_CYC-1.
  - Otherwise, if rst_n_out[i] == 0: when hold[i] == 0, rst_n_out[i] ← 1; else hold[i] decrements.
  - A request while a channel is already held reloads hold[i].
  - soft_rst_req is ignored in PWR and REL.
- btn_sync == 0 in any state:
  - all rst_n_out ← 0, hold ← 0, cnt ← 0, ch_idx ← 0, state ← PWR.
  - cnt stays 0 while btn_sync is low. The power-on delay restarts when btn_sync returns to 1.
  - btn has priority over all soft requests and over state transitions in the same cycle.
- all_ready = (state == RUN) & (&rst_n_out). It is combinational from flops, glitch-free.
- Counter width is $clog2(max(PWR_CYC, STAGGER_CYC)). Hold width is $clog2(HOLD_CYC+1). No wrap is possible, because the compare terminates counting.

## Timing
- T0 is the first clk_125 rising edge with rstn high. rst_sync_n rises at edge T0+1.
- rst_n_out[i] rises at edge T0+PWR_CYC+1+i·STAGGER_CYC. all_ready rises with the last channel.
- Soft request sampled at edge E: rst_n_out[i] is low from E, and high again at E+HOLD_CYC. The channel is low for exactly HOLD_CYC cycles after the last request cycle.
- btn_n falls: outputs go low 3 edges later (2 sync + 1 register).
- btn_n released at edge B: ch0 rises at B+2+PWR_CYC, i.e. 2 sync edges, then 1 edge to leave the held-0 condition, then PWR_CYC.
- rstn low mid-operation: outputs go to 0 immediately and asynchronously. The sequence restarts from T0.

## Structure
- Shared package rst_seq_pkg holds:
  - state encoding constants ST_PWR, ST_REL, ST_RUN
  - the sync stage count (2).
- Sub-module reset_hold_ch holds one channel's hold counter and rst_n_out bit. Inputs: req, load (release event), clr (btn), run. It is instantiated NUM_CH times via generate.
- Top holds the synchronisers, the main FSM, cnt and ch_idx.

## Test plan
- NUM_CH=3, PWR_CYC=16, STAGGER_CYC=4, HOLD_CYC=8; release rstn at T0 -> rst_n_out = 001 at T0+17, 011 at T0+21, 111 at T0+25; all_ready is high at T0+25 and state_dbg=2.
- In RUN, 1-cycle pulse on soft_rst_req[1] at edge E -> rst_n_out=101 for edges E..E+7, 111 at E+8; all_ready is low for the same window.
- Repeated soft_rst_req[2] at E and E+5 -> channel 2 stays low until E+13.
- btn_n low 10 cycles in RUN, released at B -> outputs are 000 from 3 edges after the fall; ch0 rises at B+18, ch2 at B+26.
- soft_rst_req=111 held throughout PWR/REL -> release times are unchanged from the first scenario.
- rstn asserted between ch1 and ch2 release -> outputs go to 000 asynchronously; after re-release the full sequence repeats with the first-scenario timing.
- NUM_CH=1, STAGGER_CYC=1 -> ch0 rises at T0+PWR_CYC+1 with direct PWR→RUN, and all_ready rises in the same cycle.
